// File: rtl/cpu_pkg.sv
// Shared CPU constants: default PC width/reset value, next-PC select encoding and
// branch opcodes used by the instruction FSM.
package cpu_pkg;

  localparam int PC_AW = 16;
  localparam logic [PC_AW-1:0] PC_RESET_VAL = '0;

  typedef enum logic [2:0] {
    NPC_HOLD,
    NPC_INC,
    NPC_ABS,
    NPC_REL,
    NPC_RET
  } npc_sel_e;

  localparam logic [3:0] JCOND = 4'h8;
  localparam logic [3:0] JUC   = 4'h9;
  localparam logic [3:0] BEQ   = 4'hA;
  localparam logic [3:0] BNEQ  = 4'hB;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: push/pop take effect on the next edge, top is decoded from registers.
// Pop has priority over push; overflow/underflow leave the pointer alone and set a sticky err.
module ras_stack #(
  parameter int AW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [AW-1:0] push_dat,
  input  logic          pop_vld,
  output logic [AW-1:0] top_dat,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE  = (PW+1)'(1);
  localparam logic [PW:0] PTR_FULL = (PW+1)'(DEPTH);

  logic [PW:0]   ptr_q, ptr_d, ptr_m1;
  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic          err_q, err_d;

  assign ptr_m1  = ptr_q - PTR_ONE;
  assign full    = (ptr_q == PTR_FULL);
  assign empty   = (ptr_q == '0);
  assign err     = err_q;
  assign top_dat = empty ? '0 : mem_q[ptr_m1[PW-1:0]];

  always_comb begin
    ptr_d = ptr_q;
    err_d = err_q;
    mem_d = mem_q;
    if (pop_vld) begin
      if (empty) err_d = 1'b1;
      else       ptr_d = ptr_m1;
    end else if (push_vld) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        mem_d[ptr_q[PW-1:0]] = push_dat;
        ptr_d = ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter: strobes sampled at an edge show on pc after that edge; no backpressure.
// Define PC_UNIT_RAS_EN for a DEPTH-entry return stack; otherwise a single link register.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int            AW       = PC_AW,
  parameter int            DW       = 8,
  parameter int            DEPTH    = 8,
  parameter logic [AW-1:0] RESET_PC = AW'(PC_RESET_VAL)
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          PC_inc,
  input  logic          JAddrSelect,
  input  logic          rel_sel,
  input  logic [AW-1:0] jaddr,
  input  logic [DW-1:0] disp,
  input  logic          call,
  input  logic          ret,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] link,
  output logic          stk_empty,
  output logic          stk_full,
  output logic          stk_err
);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_plus1, pc_rel, top;
  logic          do_push, empty;
  npc_sel_e      npc_sel;

  assign pc_plus1 = pc_q + AW'(1);
  assign pc_rel   = pc_q + {{(AW-DW){disp[DW-1]}}, disp};
  // A simultaneous ret drops the jump, and with it the call's push.
  assign do_push  = call & JAddrSelect & ~ret;

  always_comb begin
    npc_sel = NPC_HOLD;
    if (ret)                         npc_sel = NPC_RET;
    else if (JAddrSelect && rel_sel) npc_sel = NPC_REL;
    else if (JAddrSelect)            npc_sel = NPC_ABS;
    else if (PC_inc)                 npc_sel = NPC_INC;
  end

  always_comb begin
    pc_d = pc_q;
    case (npc_sel)
      NPC_RET: pc_d = empty ? pc_q : top;
      NPC_REL: pc_d = pc_rel;
      NPC_ABS: pc_d = jaddr;
      NPC_INC: pc_d = pc_plus1;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

`ifdef PC_UNIT_RAS_EN
  logic full, err;

  ras_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ras_stack (
    .clk      (CLK),
    .rst_n    (CLR),
    .push_vld (do_push),
    .push_dat (pc_plus1),
    .pop_vld  (ret),
    .top_dat  (top),
    .full     (full),
    .empty    (empty),
    .err      (err)
  );

  assign stk_full = full;
  assign stk_err  = err;
`else
  logic [AW-1:0] link_q, link_d;
  logic          used_q, used_d;
  logic          err_q, err_d;

  // Single link register: never overflows, ret reads it without consuming it.
  always_comb begin
    link_d = do_push ? pc_plus1 : link_q;
    used_d = used_q | do_push;
    err_d  = err_q | (ret & ~used_q);
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      link_q <= '0;
      used_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      link_q <= link_d;
      used_q <= used_d;
      err_q  <= err_d;
    end
  end

  assign top      = link_q;
  assign empty    = ~used_q;
  assign stk_full = 1'b0;
  assign stk_err  = err_q;
`endif

  assign pc        = pc_q;
  assign link      = top;
  assign stk_empty = empty;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; expectations follow the build selected by PC_UNIT_RAS_EN.
module tb_pc_unit;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        PC_inc, JAddrSelect, rel_sel, call, ret;
  logic [15:0] jaddr;
  logic [7:0]  disp;
  logic [15:0] pc, link;
  logic        stk_empty, stk_full, stk_err;

  int errs   = 0;
  int checks = 0;

  pc_unit #(.AW(16), .DW(8), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .PC_inc      (PC_inc),
    .JAddrSelect (JAddrSelect),
    .rel_sel     (rel_sel),
    .jaddr       (jaddr),
    .disp        (disp),
    .call        (call),
    .ret         (ret),
    .pc          (pc),
    .link        (link),
    .stk_empty   (stk_empty),
    .stk_full    (stk_full),
    .stk_err     (stk_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of strobes, then sample 1 time unit after the edge.
  task automatic cyc(input logic clr_n, input logic inc, input logic js, input logic rs,
                     input logic cl, input logic rt, input logic [15:0] ja, input logic [7:0] d);
    CLR = clr_n; PC_inc = inc; JAddrSelect = js; rel_sel = rs;
    call = cl; ret = rt; jaddr = ja; disp = d;
    @(posedge CLK);
    #1;
    CLR = 1'b1; PC_inc = 1'b0; JAddrSelect = 1'b0; rel_sel = 1'b0;
    call = 1'b0; ret = 1'b0; jaddr = 16'h0; disp = 8'h0;
  endtask

  task automatic jmp_abs(input logic [15:0] a);
    cyc(1, 0, 1, 0, 0, 0, a, 8'h00);
  endtask

  initial begin
    CLR = 1'b0; PC_inc = 1'b0; JAddrSelect = 1'b0; rel_sel = 1'b0;
    call = 1'b0; ret = 1'b0; jaddr = 16'h0; disp = 8'h0;
    #1;

    cyc(0, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    cyc(0, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_empty", stk_empty, 1);
    chk("rst_full", stk_full, 0);
    chk("rst_err", stk_err, 0);
    chk("rst_link", link, 16'h0000);

    cyc(0, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("rst_beats_inc", pc, 16'h0000);
    cyc(1, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("inc1", pc, 16'h0001);
    cyc(1, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("inc2", pc, 16'h0002);
    cyc(1, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("inc3", pc, 16'h0003);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("hold", pc, 16'h0003);

    jmp_abs(16'h0010);
    chk("abs_0010", pc, 16'h0010);
    cyc(1, 1, 1, 0, 0, 0, 16'h0200, 8'h0);
    chk("jump_beats_inc", pc, 16'h0200);

    jmp_abs(16'h0002);
    cyc(1, 0, 1, 1, 0, 0, 16'h1234, 8'hFC);
    chk("rel_neg", pc, 16'hFFFE);
    cyc(1, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("inc_ffff", pc, 16'hFFFF);
    cyc(1, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("inc_wrap", pc, 16'h0000);
    cyc(1, 1, 1, 1, 0, 0, 16'h0, 8'h05);
    chk("rel_pos", pc, 16'h0005);
    cyc(1, 0, 1, 1, 0, 0, 16'h0, 8'h7F);
    chk("rel_max", pc, 16'h0084);

    jmp_abs(16'h0040);
    cyc(1, 0, 0, 0, 1, 0, 16'h0999, 8'h0);
    chk("call_no_jsel_ignored", pc, 16'h0040);
    chk("call_no_jsel_empty", stk_empty, 1);
    cyc(1, 0, 1, 0, 1, 0, 16'h0100, 8'h0);
    chk("call_pc", pc, 16'h0100);
    chk("call_link", link, 16'h0041);
    chk("call_nonempty", stk_empty, 0);
    cyc(1, 0, 0, 0, 0, 1, 16'h0, 8'h0);
    chk("ret_pc", pc, 16'h0041);
`ifdef PC_UNIT_RAS_EN
    chk("ret_empty", stk_empty, 1);
`else
    chk("ret_keeps_link", link, 16'h0041);
`endif

    cyc(1, 0, 1, 0, 1, 0, 16'h0300, 8'h0);
    chk("call2_link", link, 16'h0042);
    cyc(1, 1, 1, 0, 0, 1, 16'h0555, 8'h0);
    chk("ret_beats_jump", pc, 16'h0042);
    chk("no_err_yet", stk_err, 0);

`ifdef PC_UNIT_RAS_EN
    jmp_abs(16'h0800);
    for (int k = 0; k <= DEPTH; k++) begin
      cyc(1, 0, 1, 0, 1, 0, 16'h1000 + 16'(k * 16), 8'h0);
      chk("nest_pc", pc, 16'h1000 + 32'(k * 16));
      if (k == DEPTH - 1) begin
        chk("full_at_depth", stk_full, 1);
        chk("no_err_at_depth", stk_err, 0);
      end
    end
    chk("ovf_err", stk_err, 1);
    chk("ovf_full", stk_full, 1);
    chk("ovf_link", link, 16'h1061);
    for (int j = 0; j < DEPTH; j++) begin
      cyc(1, 0, 0, 0, 0, 1, 16'h0, 8'h0);
      chk("unwind_pc", pc, (j == DEPTH - 1) ? 32'h0801 : 32'h1000 + 32'((DEPTH - 2 - j) * 16) + 1);
    end
    chk("unwound_empty", stk_empty, 1);
    chk("unwound_link", link, 16'h0000);
    cyc(1, 0, 0, 0, 0, 1, 16'h0, 8'h0);
    chk("udf_pc_holds", pc, 16'h0801);
    chk("udf_err", stk_err, 1);
    cyc(1, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("err_sticky", stk_err, 1);
    cyc(0, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("err_cleared", stk_err, 0);
`else
    jmp_abs(16'h0010);
    cyc(1, 0, 1, 0, 1, 0, 16'h0020, 8'h0);
    chk("lr_call1", link, 16'h0011);
    cyc(1, 0, 1, 0, 1, 0, 16'h0050, 8'h0);
    chk("lr_call2", link, 16'h0021);
    chk("lr_never_full", stk_full, 0);
    cyc(1, 0, 0, 0, 0, 1, 16'h0, 8'h0);
    chk("lr_ret1", pc, 16'h0021);
    cyc(1, 1, 0, 0, 0, 0, 16'h0, 8'h0);
    cyc(1, 0, 0, 0, 0, 1, 16'h0, 8'h0);
    chk("lr_ret2", pc, 16'h0021);
    chk("lr_no_err", stk_err, 0);
    cyc(0, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    cyc(1, 0, 0, 0, 0, 1, 16'h0, 8'h0);
    chk("lr_udf_pc", pc, 16'h0000);
    chk("lr_udf_err", stk_err, 1);
    chk("lr_udf_empty", stk_empty, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly upstream of the instruction FSM.
- Holds the fetch address that drives instruction memory. Applies the FSM's per-instruction PC_inc / JAddrSelect strobes.
- Resolves absolute jumps, PC-relative branches, call-link pushes and returns.
- Provides a call/return address stack so subroutine returns do not consume a general register.

Parameters:
- AW, 16, PC/address width in bits.
- DW, 8, relative displacement width (instruction immediate field), sign-extended to AW.
- DEPTH, 8, return-address stack entries (power of two, >=2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- CLR  in  1  reset; synchronous, active-low (CLR==0 at posedge resets).
- PC_inc  in  1  FSM strobe: advance PC by 1 this cycle.
- JAddrSelect  in  1  FSM strobe: take branch/jump this cycle.
- rel_sel  in  1  qualifies JAddrSelect: 1 = PC-relative, 0 = absolute.
- jaddr  in  AW  absolute target (register-file read data).
- disp  in  DW  signed displacement for relative branch.
- call  in  1  qualifies JAddrSelect: push PC+1 before jumping.
- ret  in  1  pop stack top into PC (independent of JAddrSelect).
- pc  out  AW  current fetch address (registered).
- link  out  AW  stack top value (0 when empty).
- stk_empty  out  1  stack holds 0 entries.
- stk_full  out  1  stack holds DEPTH entries.
- stk_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (CLR==0 at posedge): pc=RESET_PC, stack pointer=0, stk_empty=1, stk_full=0, stk_err=0, link=0. Reset wins over every other input, including mid-call/ret.
- All outputs are registered or decoded from registers. A strobe sampled at edge N is visible on pc after edge N (1-cycle latency).
- Next-PC priority, highest first:
  1. ret.
  2. JAddrSelect with rel_sel=1: pc+sext(disp).
  3. JAddrSelect with rel_sel=0: jaddr.
  4. PC_inc: pc+1.
  5. Otherwise pc holds.
- PC_inc asserted together with JAddrSelect is ignored (jump wins).
- All PC arithmetic is modulo 2^AW: 0xFFFF+1 -> 0x0000; 0x0002+sext(0xFC) -> 0xFFFE.
- Relative target is computed from the current pc, not pc+1.
- call with JAddrSelect=1: push pc+1, then jump. call without JAddrSelect is ignored.
- ret: pc <= top, pop.
- ret and JAddrSelect together: ret wins, jump dropped.
- Overflow (push when full): no write, pointer unchanged, jump still taken, stk_err=1.
- Underflow (ret when empty): pc holds, stk_err=1.
- stk_err clears only on reset.
- Stack is a register array indexed by pointer 0..DEPTH. link=array[ptr-1].

Optional Feature:
- Macro: PC_UNIT_RAS_EN.
- Defined: full DEPTH-entry stack as above.
- Undefined: single link register. call overwrites it unconditionally (never overflow). ret loads pc from it and leaves it unchanged. stk_empty=1 until the first call. stk_full tied 0. stk_err set only by ret before any call.
- Port list is identical in both builds.

Decomposition:
- Shared package cpu_pkg: AW default constant, RESET_PC, and the strobe-priority encoding enum {NPC_HOLD, NPC_INC, NPC_ABS, NPC_REL, NPC_RET}.
- The same package should also hold the FSM opcode constants (JCOND, JUC, BEQ, BNEQ) for reuse.
- One sub-module: ras_stack (push/pop/top/full/empty/err, parameter DEPTH). It is instantiated only under PC_UNIT_RAS_EN.
- Next-PC mux stays in pc_unit.

Test Plan:
- Reset then PC_inc for 3 cycles -> pc 0,1,2,3. Hold CLR=0 with PC_inc=1 -> pc stays 0.
- pc=0x0010, JAddrSelect=1, rel_sel=0, jaddr=0x0200, PC_inc=1 simultaneously -> pc=0x0200 next cycle (not 0x0011).
- pc=0x0002, rel_sel=1, disp=0xFC -> pc=0xFFFE. Then PC_inc -> 0xFFFF. Then PC_inc -> 0x0000.
- pc=0x0040, call+JAddrSelect, jaddr=0x0100 -> pc=0x0100, link=0x0041, stk_empty=0. Then ret -> pc=0x0041, stk_empty=1.
- DEPTH+1 nested calls -> stk_full=1 after DEPTH; last call jumps but stk_err=1. Then ret on empty after DEPTH returns -> pc holds, stk_err stays 1 until CLR=0.
- Build without PC_UNIT_RAS_EN: two calls (link 0x0011 then 0x0021), ret -> pc=0x0021. Ret again -> pc=0x0021, stk_err=0.
